// File: rtl/yutorina_ex_stage.sv
// yutorina_ex_stage
// Execute stage of the Yutorina pipeline. Takes the ID/EX bundle, computes the
// ALU result, and registers result plus pass-through control into EX/MEM.
// Drives the EX forwarding pair back to decode. An optional iterative
// multiply/divide unit stalls upstream through ex_busy while it iterates.
//
// Build option:
//   YUTORINA_MULDIV_EN  defined: 32-step shift-add multiplier / restoring
//                       divider with IDLE/BUSY sequencing.
//                       undefined: MUL/MULHU/DIVU/REMU retire in one cycle as
//                       undefined instructions and ex_busy is tied low.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   stall, flush        hold all state / squash and load a bubble
//   id_*                ID/EX bundle (id_en_, id_gpr_we_ active-low)
//   ex_*                registered EX/MEM bundle (ex_en_, ex_gpr_we_ active-low)
//   ex_fwd_addr/out     forwarding pair; address masked to GPR zero unless the
//                       registered op is valid and writes a GPR
//   ex_busy             multi-cycle op in progress, upstream must hold ID/EX
//
// Bus encodings mirror the shared isa.h / gpr.h / exp.h definitions.

module yutorina_ex_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        id_en_,
    input  logic [3:0]  id_alu_op,
    input  logic [31:0] id_alu_lhs,
    input  logic [31:0] id_alu_rhs,
    input  logic [4:0]  id_w_addr,
    input  logic [31:0] id_w_data,
    input  logic        id_gpr_we_,
    input  logic [1:0]  id_mem_op,
    input  logic [1:0]  id_ctrl_op,
    input  logic [2:0]  id_exp_code,
    output logic        ex_en_,
    output logic [31:0] ex_alu_out,
    output logic [4:0]  ex_w_addr,
    output logic [31:0] ex_w_data,
    output logic        ex_gpr_we_,
    output logic [1:0]  ex_mem_op,
    output logic [1:0]  ex_ctrl_op,
    output logic [2:0]  ex_exp_code,
    output logic [4:0]  ex_fwd_addr,
    output logic [31:0] ex_fwd_out,
    output logic        ex_busy
);

    localparam logic       ENABLE_  = 1'b0;
    localparam logic       DISABLE_ = 1'b1;

    localparam logic [3:0] ALU_NOP   = 4'd0;
    localparam logic [3:0] ALU_ADD   = 4'd1;
    localparam logic [3:0] ALU_SUB   = 4'd2;
    localparam logic [3:0] ALU_AND   = 4'd3;
    localparam logic [3:0] ALU_OR    = 4'd4;
    localparam logic [3:0] ALU_XOR   = 4'd5;
    localparam logic [3:0] ALU_SHRA  = 4'd6;
    localparam logic [3:0] ALU_SHLL  = 4'd7;
    localparam logic [3:0] ALU_SHRL  = 4'd8;
    localparam logic [3:0] ALU_SLT   = 4'd9;
    localparam logic [3:0] ALU_SLTU  = 4'd10;
    localparam logic [3:0] ALU_MUL   = 4'd11;
    localparam logic [3:0] ALU_MULHU = 4'd12;
    localparam logic [3:0] ALU_DIVU  = 4'd13;
    localparam logic [3:0] ALU_REMU  = 4'd14;

    localparam logic [4:0] GPR_ZERO  = 5'd0;
    localparam logic [1:0] MEM_NONE  = 2'd0;
    localparam logic [1:0] CTRL_NONE = 2'd0;

    localparam logic [2:0] EXP_NONE       = 3'd0;
    localparam logic [2:0] EXP_UNDEF_INSN = 3'd2;
    localparam logic [2:0] EXP_OVERFLOW   = 3'd3;

    // ------------------------------------------------------------------
    // Single-cycle ALU
    // ------------------------------------------------------------------
    logic [31:0] alu_sum;
    logic [31:0] alu_diff;
    logic [31:0] alu_res;
    logic        alu_ovf;
    logic        is_muldiv;

    assign alu_sum   = id_alu_lhs + id_alu_rhs;
    assign alu_diff  = id_alu_lhs - id_alu_rhs;
    assign is_muldiv = (id_alu_op == ALU_MUL)  || (id_alu_op == ALU_MULHU) ||
                       (id_alu_op == ALU_DIVU) || (id_alu_op == ALU_REMU);

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (id_alu_op)
            ALU_NOP:  alu_res = '0;
            ALU_ADD: begin
                alu_res = alu_sum;
                alu_ovf = (id_alu_lhs[31] == id_alu_rhs[31]) && (alu_sum[31] != id_alu_lhs[31]);
            end
            ALU_SUB: begin
                alu_res = alu_diff;
                alu_ovf = (id_alu_lhs[31] != id_alu_rhs[31]) && (alu_diff[31] != id_alu_lhs[31]);
            end
            ALU_AND:  alu_res = id_alu_lhs & id_alu_rhs;
            ALU_OR:   alu_res = id_alu_lhs | id_alu_rhs;
            ALU_XOR:  alu_res = id_alu_lhs ^ id_alu_rhs;
            ALU_SHRA: alu_res = $unsigned($signed(id_alu_lhs) >>> id_alu_rhs[4:0]);
            ALU_SHLL: alu_res = id_alu_lhs << id_alu_rhs[4:0];
            ALU_SHRL: alu_res = id_alu_lhs >> id_alu_rhs[4:0];
            ALU_SLT:  alu_res = {31'b0, $signed(id_alu_lhs) < $signed(id_alu_rhs)};
            ALU_SLTU: alu_res = {31'b0, id_alu_lhs < id_alu_rhs};
            default:  alu_res = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Iterative multiply/divide
    // ------------------------------------------------------------------
    logic        md_start;   // IDLE and a valid MULDIV op is presented
    logic        md_busy_st; // FSM in BUSY
    logic        md_last;    // BUSY on its final iteration
    logic [31:0] md_result;

`ifdef YUTORINA_MULDIV_EN
    // state | meaning
    // IDLE  | single-cycle ops flow through; a MULDIV op latches and starts
    // BUSY  | one iteration per cycle; bubbles out until cnt==31 retires
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [0:0]  state;
    logic [4:0]  cnt;
    logic [1:0]  md_kind;    // 0 MUL, 1 MULHU, 2 DIVU, 3 REMU
    logic [1:0]  kind_in;
    logic [31:0] md_opa;     // multiplicand
    logic [31:0] md_opb;     // divisor
    logic [63:0] md_acc;     // mul: {partial hi, remaining multiplier}; div: {rem, quot}
    logic [63:0] md_acc_nx;
    logic [32:0] mul_sum;
    logic [32:0] rem_sh;
    logic        rem_ge;
    logic [31:0] rem_diff;

    always_comb begin
        kind_in = 2'd0;
        case (id_alu_op)
            ALU_MULHU: kind_in = 2'd1;
            ALU_DIVU:  kind_in = 2'd2;
            ALU_REMU:  kind_in = 2'd3;
            default:   kind_in = 2'd0;
        endcase
    end

    // Multiply: add multiplicand into the high half when the multiplier LSB
    // is set, then shift the whole accumulator right (carry enters bit 63).
    assign mul_sum = {1'b0, md_acc[63:32]} + (md_acc[0] ? {1'b0, md_opa} : 33'd0);

    // Restoring divide: shift the next dividend bit into the remainder and
    // subtract when it fits. A zero divisor always fits, which yields an
    // all-ones quotient and leaves the dividend as the remainder.
    assign rem_sh   = {md_acc[63:32], md_acc[31]};
    assign rem_ge   = rem_sh >= {1'b0, md_opb};
    assign rem_diff = rem_sh[31:0] - md_opb;

    assign md_acc_nx = md_kind[1] ? {(rem_ge ? rem_diff : rem_sh[31:0]), md_acc[30:0], rem_ge}
                                  : {mul_sum, md_acc[31:1]};

    always_comb begin
        md_result = '0;
        case (md_kind)
            2'd0:    md_result = md_acc_nx[31:0];
            2'd1:    md_result = md_acc_nx[63:32];
            2'd2:    md_result = md_acc_nx[31:0];
            default: md_result = md_acc_nx[63:32];
        endcase
    end

    assign md_busy_st = (state == BUSY);
    assign md_last    = md_busy_st && (cnt == 5'd31);
    assign md_start   = (state == IDLE) && (id_en_ == ENABLE_) && is_muldiv &&
                        (id_exp_code == EXP_NONE);
    assign ex_busy    = md_start || (md_busy_st && !md_last);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state   <= IDLE;
            cnt     <= '0;
            md_kind <= '0;
            md_opa  <= '0;
            md_opb  <= '0;
            md_acc  <= '0;
        end else if (!stall) begin
            if (md_start) begin
                state   <= BUSY;
                cnt     <= '0;
                md_kind <= kind_in;
                md_opa  <= id_alu_lhs;
                md_opb  <= id_alu_rhs;
                md_acc  <= {32'b0, kind_in[1] ? id_alu_lhs : id_alu_rhs};
            end else if (md_busy_st) begin
                md_acc <= md_acc_nx;
                cnt    <= cnt + 5'd1;
                if (md_last) begin
                    state <= IDLE;
                end
            end
        end
    end
`else
    assign md_start   = 1'b0;
    assign md_busy_st = 1'b0;
    assign md_last    = 1'b0;
    assign md_result  = '0;
    assign ex_busy    = 1'b0;
`endif

    // ------------------------------------------------------------------
    // EX/MEM register
    // ------------------------------------------------------------------
    logic        nx_bubble;
    logic [31:0] nx_alu;
    logic        nx_we;
    logic [2:0]  nx_exp;

    always_comb begin
        nx_bubble = 1'b0;
        nx_alu    = alu_res;
        nx_we     = id_gpr_we_;
        nx_exp    = id_exp_code;
        if (md_busy_st) begin
            // Pass-through fields come from the ID/EX bundle held upstream.
            if (md_last) begin
                nx_alu = md_result;
            end else begin
                nx_bubble = 1'b1;
            end
        end else if ((id_en_ == DISABLE_) || md_start) begin
            nx_bubble = 1'b1;
        end else if (is_muldiv) begin
            nx_alu = '0;
            nx_we  = DISABLE_;
            if (id_exp_code == EXP_NONE) begin
                nx_exp = EXP_UNDEF_INSN;
            end
        end else if ((id_exp_code == EXP_NONE) && alu_ovf) begin
            nx_we  = DISABLE_;
            nx_exp = EXP_OVERFLOW;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush || (!stall && nx_bubble)) begin
            ex_en_      <= DISABLE_;
            ex_alu_out  <= '0;
            ex_w_addr   <= GPR_ZERO;
            ex_w_data   <= '0;
            ex_gpr_we_  <= DISABLE_;
            ex_mem_op   <= MEM_NONE;
            ex_ctrl_op  <= CTRL_NONE;
            ex_exp_code <= EXP_NONE;
        end else if (!stall) begin
            ex_en_      <= ENABLE_;
            ex_alu_out  <= nx_alu;
            ex_w_addr   <= id_w_addr;
            ex_w_data   <= id_w_data;
            ex_gpr_we_  <= nx_we;
            ex_mem_op   <= id_mem_op;
            ex_ctrl_op  <= id_ctrl_op;
            ex_exp_code <= nx_exp;
        end
    end

    // Decode matches on address alone, so a non-writing op must not alias.
    assign ex_fwd_addr = ((ex_en_ == ENABLE_) && (ex_gpr_we_ == ENABLE_)) ? ex_w_addr : GPR_ZERO;
    assign ex_fwd_out  = ex_alu_out;

endmodule

// File: tb/tb_yutorina_ex_stage.sv
// tb_yutorina_ex_stage
// Randomized and directed bench for yutorina_ex_stage against an arithmetic
// reference model. Follows YUTORINA_MULDIV_EN the same way the design does.

module tb_yutorina_ex_stage;

    localparam logic       EN  = 1'b0;
    localparam logic       DIS = 1'b1;

    localparam logic [3:0] NOP = 4'd0, ADD = 4'd1, SUB = 4'd2, AND_ = 4'd3, OR_ = 4'd4,
                           XOR_ = 4'd5, SHRA = 4'd6, SHLL = 4'd7, SHRL = 4'd8,
                           SLT = 4'd9, SLTU = 4'd10, MUL = 4'd11, MULHU = 4'd12,
                           DIVU = 4'd13, REMU = 4'd14;

    localparam logic [2:0] X_NONE = 3'd0, X_UNDEF = 3'd2, X_OVF = 3'd3;

    logic        clk = 1'b0;
    logic        rst, stall, flush, id_en_, id_gpr_we_;
    logic [3:0]  id_alu_op;
    logic [31:0] id_alu_lhs, id_alu_rhs, id_w_data;
    logic [4:0]  id_w_addr;
    logic [1:0]  id_mem_op, id_ctrl_op;
    logic [2:0]  id_exp_code;
    logic        ex_en_, ex_gpr_we_, ex_busy;
    logic [31:0] ex_alu_out, ex_w_data, ex_fwd_out;
    logic [4:0]  ex_w_addr, ex_fwd_addr;
    logic [1:0]  ex_mem_op, ex_ctrl_op;
    logic [2:0]  ex_exp_code;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    yutorina_ex_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_en_(id_en_),
        .id_alu_op(id_alu_op), .id_alu_lhs(id_alu_lhs), .id_alu_rhs(id_alu_rhs),
        .id_w_addr(id_w_addr), .id_w_data(id_w_data), .id_gpr_we_(id_gpr_we_),
        .id_mem_op(id_mem_op), .id_ctrl_op(id_ctrl_op), .id_exp_code(id_exp_code),
        .ex_en_(ex_en_), .ex_alu_out(ex_alu_out), .ex_w_addr(ex_w_addr),
        .ex_w_data(ex_w_data), .ex_gpr_we_(ex_gpr_we_), .ex_mem_op(ex_mem_op),
        .ex_ctrl_op(ex_ctrl_op), .ex_exp_code(ex_exp_code),
        .ex_fwd_addr(ex_fwd_addr), .ex_fwd_out(ex_fwd_out), .ex_busy(ex_busy)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            ADD:     return a + b;
            SUB:     return a - b;
            AND_:    return a & b;
            OR_:     return a | b;
            XOR_:    return a ^ b;
            SHLL:    return a << b[4:0];
            SHRL:    return a >> b[4:0];
            SHRA:    return $unsigned($signed(a) >>> b[4:0]);
            SLT:     return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            SLTU:    return (a < b) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic bit ref_ovf(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (op == ADD)      r = sa + sb;
        else if (op == SUB) r = sa - sb;
        else                return 1'b0;
        return (r > 64'sd2147483647) || (r < -64'sd2147483648);
    endfunction

    function automatic logic [31:0] ref_md(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = {32'b0, a} * {32'b0, b};
        case (op)
            MUL:     return p[31:0];
            MULHU:   return p[63:32];
            DIVU:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit is_md(input logic [3:0] op);
        return (op == MUL) || (op == MULHU) || (op == DIVU) || (op == REMU);
    endfunction

    task automatic idle_inputs();
        id_en_ = DIS; id_alu_op = NOP; id_alu_lhs = '0; id_alu_rhs = '0;
        id_w_addr = '0; id_w_data = '0; id_gpr_we_ = DIS;
        id_mem_op = '0; id_ctrl_op = '0; id_exp_code = X_NONE;
    endtask

    task automatic check_bubble(input string tag, input bit full);
        check_val({tag, "_en"}, ex_en_, DIS);
        check_val({tag, "_we"}, ex_gpr_we_, DIS);
        check_val({tag, "_fwd_addr"}, ex_fwd_addr, 0);
        if (full) begin
            check_val({tag, "_alu"}, ex_alu_out, 0);
            check_val({tag, "_wdata"}, ex_w_data, 0);
            check_val({tag, "_waddr"}, ex_w_addr, 0);
            check_val({tag, "_mem"}, ex_mem_op, 0);
            check_val({tag, "_ctrl"}, ex_ctrl_op, 0);
            check_val({tag, "_exp"}, ex_exp_code, X_NONE);
        end
    endtask

    // Drive one op, clock it in, compare every registered output.
    task automatic run_single(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                              input logic [4:0] wa, input logic [31:0] wd, input logic we,
                              input logic [1:0] mem, input logic [1:0] ctrl, input logic [2:0] xc,
                              input logic en, input string tag);
        logic [31:0] e_alu;
        logic        e_we;
        logic [2:0]  e_exp;
        id_en_ = en; id_alu_op = op; id_alu_lhs = a; id_alu_rhs = b;
        id_w_addr = wa; id_w_data = wd; id_gpr_we_ = we;
        id_mem_op = mem; id_ctrl_op = ctrl; id_exp_code = xc;
        #1;
        check_val({tag, "_busy"}, ex_busy, 0);
        @(posedge clk); #1;
        if (en == DIS) begin
            check_bubble(tag, 1'b0);
        end else begin
            if (is_md(op)) begin
                e_alu = 0; e_we = DIS; e_exp = (xc != X_NONE) ? xc : X_UNDEF;
            end else if (xc != X_NONE) begin
                e_alu = ref_alu(op, a, b); e_we = we; e_exp = xc;
            end else if (ref_ovf(op, a, b)) begin
                e_alu = ref_alu(op, a, b); e_we = DIS; e_exp = X_OVF;
            end else begin
                e_alu = ref_alu(op, a, b); e_we = we; e_exp = X_NONE;
            end
            check_val({tag, "_en"}, ex_en_, EN);
            check_val({tag, "_alu"}, ex_alu_out, e_alu);
            check_val({tag, "_we"}, ex_gpr_we_, e_we);
            check_val({tag, "_exp"}, ex_exp_code, e_exp);
            check_val({tag, "_waddr"}, ex_w_addr, wa);
            check_val({tag, "_wdata"}, ex_w_data, wd);
            check_val({tag, "_mem"}, ex_mem_op, mem);
            check_val({tag, "_ctrl"}, ex_ctrl_op, ctrl);
            check_val({tag, "_fwd_addr"}, ex_fwd_addr, (e_we == EN) ? wa : 5'd0);
            check_val({tag, "_fwd_out"}, ex_fwd_out, e_alu);
        end
    endtask

    // Multi-cycle op: count busy cycles and result latency. stall_at >= 0
    // holds stall for 3 cycles from that cycle; abort 1 = flush, 2 = rst at cnt 10.
    task automatic run_muldiv(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                              input int stall_at, input int abort, input string tag);
        logic [31:0] e;
        int c, busy_n, nst;
        bit done, bad, seen;
        e = ref_md(op, a, b);
        nst = (stall_at >= 0) ? 3 : 0;
        c = 0; busy_n = 0; done = 0; bad = 0; seen = 0;
        id_en_ = EN; id_alu_op = op; id_alu_lhs = a; id_alu_rhs = b;
        id_w_addr = 5'd7; id_w_data = 32'hCAFE_0000 | {16'b0, a[15:0]}; id_gpr_we_ = EN;
        id_mem_op = 2'd1; id_ctrl_op = 2'd2; id_exp_code = X_NONE;
        #1;
        while (c < 80 && !done) begin
            if (ex_busy) busy_n++;
            if (abort != 0 && c == 11) begin
                if (abort == 1) flush = 1'b1; else rst = 1'b1;
                @(posedge clk); #1;
                flush = 1'b0; rst = 1'b0;
                id_en_ = DIS;
                #1;
                check_val({tag, "_abort_busy"}, ex_busy, 0);
                check_bubble({tag, "_abort"}, 1'b1);
                repeat (40) begin
                    @(posedge clk); #1;
                    if (ex_en_ === EN || ex_busy === 1'b1) seen = 1;
                end
                check_val({tag, "_no_result"}, seen, 0);
                idle_inputs();
                return;
            end
            if (c >= 1 && (ex_en_ !== DIS || ex_fwd_addr !== 5'd0)) bad = 1;
            stall = (stall_at >= 0) && (c >= stall_at) && (c < stall_at + 3);
            @(posedge clk); #1;
            c++;
            if (ex_en_ === EN) done = 1;
        end
        stall = 1'b0;
        check_val({tag, "_done"}, done, 1);
        check_val({tag, "_latency"}, c, 33 + nst);
        check_val({tag, "_busy_cycles"}, busy_n, 32 + nst);
        check_val({tag, "_bubbles"}, bad, 0);
        check_val({tag, "_alu"}, ex_alu_out, e);
        check_val({tag, "_exp"}, ex_exp_code, X_NONE);
        check_val({tag, "_we"}, ex_gpr_we_, EN);
        check_val({tag, "_wdata"}, ex_w_data, 32'hCAFE_0000 | {16'b0, a[15:0]});
        check_val({tag, "_mem_ctrl"}, {ex_mem_op, ex_ctrl_op}, {2'd1, 2'd2});
        check_val({tag, "_fwd_addr"}, ex_fwd_addr, 7);
        check_val({tag, "_fwd_out"}, ex_fwd_out, e);
        idle_inputs();
        #1;
        check_val({tag, "_busy_after"}, ex_busy, 0);
    endtask

    function automatic logic [31:0] rnd_word();
        logic [31:0] edge_vals [5];
        edge_vals[0] = 32'h0; edge_vals[1] = 32'h1; edge_vals[2] = 32'h7FFF_FFFF;
        edge_vals[3] = 32'h8000_0000; edge_vals[4] = 32'hFFFF_FFFF;
        if ($urandom_range(0, 3) == 0) return edge_vals[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        idle_inputs();
        // a valid op during reset must not get through
        id_en_ = EN; id_alu_op = ADD; id_alu_lhs = 32'd1; id_alu_rhs = 32'd1;
        id_gpr_we_ = EN; id_w_addr = 5'd9; id_w_data = 32'h55;
        repeat (2) @(posedge clk);
        #1;
        check_bubble("rst", 1'b1);
        check_val("rst_fwd_out", ex_fwd_out, 0);
        check_val("rst_busy", ex_busy, 0);
        rst = 1'b0;
        idle_inputs();

        run_single(ADD, 32'd5, 32'd7, 5'd3, 32'h0, EN, 2'd0, 2'd0, X_NONE, EN, "add_5_7");
        check_val("add_5_7_is12", ex_fwd_out, 32'd12);
        check_val("add_5_7_addr3", ex_fwd_addr, 5'd3);
        run_single(ADD, 32'h7FFF_FFFF, 32'd1, 5'd4, 32'h1, EN, 2'd0, 2'd0, X_NONE, EN, "add_ovf");
        check_val("add_ovf_code", ex_exp_code, X_OVF);
        run_single(SUB, 32'h8000_0000, 32'd1, 5'd4, 32'h1, EN, 2'd0, 2'd0, X_NONE, EN, "sub_ovf");
        run_single(ADD, 32'h7FFF_FFFF, 32'd1, 5'd6, 32'h2, EN, 2'd1, 2'd1, 3'd1, EN, "ovf_exp_in");
        run_single(SHRA, 32'h8000_0010, 32'd36, 5'd8, 32'h3, EN, 2'd0, 2'd0, X_NONE, EN, "shra");
        run_single(SLT, 32'hFFFF_FFFF, 32'd1, 5'd8, 32'h3, EN, 2'd0, 2'd0, X_NONE, EN, "slt");
        run_single(SLTU, 32'hFFFF_FFFF, 32'd1, 5'd8, 32'h3, EN, 2'd0, 2'd0, X_NONE, EN, "sltu");
        run_single(ADD, 32'd1, 32'd1, 5'd9, 32'h4, EN, 2'd0, 2'd0, X_NONE, DIS, "id_dis");

        // stall holds the registered op for three cycles
        run_single(ADD, 32'd1, 32'd2, 5'd5, 32'h10, EN, 2'd0, 2'd0, X_NONE, EN, "pre_stall");
        stall = 1'b1;
        id_alu_op = XOR_; id_alu_lhs = 32'hF0F0_0000; id_alu_rhs = 32'h0F0F_0000; id_w_addr = 5'd11;
        repeat (3) begin
            @(posedge clk); #1;
            check_val("stall_alu", ex_alu_out, 32'd3);
            check_val("stall_fwd", ex_fwd_addr, 5'd5);
        end
        stall = 1'b0;
        @(posedge clk); #1;
        check_val("post_stall_alu", ex_alu_out, 32'hFFFF_0000);
        check_val("post_stall_fwd", ex_fwd_addr, 5'd11);

        // flush beats stall; a sync reset mid-run also loads the bubble
        stall = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        stall = 1'b0; flush = 1'b0;
        check_bubble("flush", 1'b1);
        run_single(OR_, 32'h1, 32'h2, 5'd12, 32'h20, EN, 2'd3, 2'd3, X_NONE, EN, "pre_rst");
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_bubble("sync_rst", 1'b1);

`ifndef YUTORINA_MULDIV_EN
        run_single(MUL, 32'hFFFF_FFFF, 32'd2, 5'd13, 32'h0, EN, 2'd0, 2'd0, X_NONE, EN, "mul_undef");
        check_val("mul_undef_code", ex_exp_code, X_UNDEF);
        run_single(DIVU, 32'd100, 32'd7, 5'd13, 32'h0, EN, 2'd0, 2'd0, X_NONE, EN, "divu_undef");
`endif

        for (int i = 0; i < 300; i++) begin
            logic [3:0] op;
`ifdef YUTORINA_MULDIV_EN
            op = 4'($urandom_range(0, 10));
`else
            op = 4'($urandom_range(0, 14));
`endif
            run_single(op, rnd_word(), rnd_word(), 5'($urandom), $urandom, 1'($urandom),
                       2'($urandom), 2'($urandom),
                       (!is_md(op) && $urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : X_NONE,
                       ($urandom_range(0, 5) == 0) ? DIS : EN, "rand");
        end

`ifdef YUTORINA_MULDIV_EN
        run_muldiv(MUL,   32'hFFFF_FFFF, 32'd2, -1, 0, "mul");
        run_muldiv(MULHU, 32'hFFFF_FFFF, 32'd2, -1, 0, "mulhu");
        run_muldiv(DIVU,  32'd100, 32'd7, -1, 0, "divu");
        run_muldiv(REMU,  32'd100, 32'd7, -1, 0, "remu");
        run_muldiv(DIVU,  32'h1234_5678, 32'd0, -1, 0, "divu_zero");
        run_muldiv(REMU,  32'd9, 32'd0, -1, 0, "remu_zero");
        run_muldiv(MUL,   32'hDEAD_BEEF, 32'h1234_5679, 10, 0, "mul_stall");
        run_muldiv(DIVU,  32'd1000, 32'd3, -1, 1, "divu_flush");
        run_muldiv(DIVU,  32'd1000, 32'd3, -1, 2, "divu_rst");
        for (int i = 0; i < 6; i++) begin
            run_muldiv(4'($urandom_range(11, 14)), rnd_word(),
                       ($urandom_range(0, 3) == 0) ? 32'd0 : rnd_word(), -1, 0, "md_rand");
        end
        run_single(ADD, 32'd2, 32'd3, 5'd1, 32'h0, EN, 2'd0, 2'd0, X_NONE, EN, "after_md");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/yutorina_ex_stage.md
# yutorina_ex_stage

Execute stage of the Yutorina pipeline: the receiving end of the ID/EX pipeline bundle. Registers ALU results and pass-through control into the EX/MEM register. Drives the EX forwarding pair back to decode. Adds an iterative multiply/divide unit that stalls upstream while busy.

## Interface
- No parameters; widths come from the shared `isa.h`/`gpr.h`/`exp.h` bus macros (word 32 b, GPR address 5 b).
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- stall  in  1  hold all state (downstream stall)
- flush  in  1  squash current op, load bubble
- id_en_  in  1  incoming op valid, active-low
- id_alu_op  in  AluOpBus  ALU operation
- id_alu_lhs, id_alu_rhs  in  32 each  operands
- id_w_addr  in  GprAddrBus  destination GPR
- id_w_data  in  32  store data, passed through
- id_gpr_we_  in  1  GPR write, active-low
- id_mem_op, id_ctrl_op, id_exp_code  in  bus macros  passed through
- ex_en_  out  1  registered valid, active-low
- ex_alu_out  out  32  registered result
- ex_w_addr, ex_w_data, ex_gpr_we_, ex_mem_op, ex_ctrl_op, ex_exp_code  out  registered pass-through
- ex_fwd_addr  out  GprAddrBus  forwarding destination to decode
- ex_fwd_out  out  32  forwarding value (= ex_alu_out)
- ex_busy  out  1  multi-cycle op in progress; upstream must hold ID/EX

## Operation
- Priority each edge: rst > flush > stall > normal.
- Reset values:
  - ex_en_=DISABLE_, ex_gpr_we_=DISABLE_
  - ex_alu_out=0, ex_w_data=0
  - ex_w_addr=GPR_ZERO
  - ex_mem_op=MEM_NONE, ex_ctrl_op=CTRL_NONE, ex_exp_code=EXP_NONE
  - state IDLE, ex_busy=0
- Flush loads the same bubble as reset, aborts any multi-cycle op, returns to IDLE.
- Stall freezes output registers, FSM and iteration counter.
- Single-cycle ops:
  - NOP → 0
  - ADD, SUB, AND, OR, XOR → 32 b wrap
  - SHLL, SHRL, SHRA → shift amount rhs[4:0]
  - SLT signed, SLTU unsigned → 1/0
- ADD/SUB signed overflow:
  - ex_exp_code=EXP_OVERFLOW, ex_gpr_we_ forced DISABLE_.
  - An incoming exp_code other than EXP_NONE takes precedence and is passed unchanged.
- id_en_ disabled: output registers load a bubble (ex_en_ disabled, we_ disabled).
- ex_fwd_addr:
  - Equals ex_w_addr when ex_en_ and ex_gpr_we_ are both enabled, else GPR_ZERO.
  - Decode compares addresses without a write-enable, so this masking is mandatory.
- FSM IDLE/BUSY (MULDIV ops only):
  - IDLE, valid MUL/MULHU/DIVU/REMU, incoming exp EXP_NONE:
    - ex_busy=1 combinationally.
    - Edge latches operands, cnt=0, →BUSY; output registers load a bubble.
  - BUSY:
    - One shift-add (mul, 64 b product) or restoring-divide step per cycle, cnt++.
    - ex_busy=1 while cnt<31.
    - Output registers keep loading bubbles, so ex_fwd_addr=GPR_ZERO.
  - BUSY, cnt==31:
    - ex_busy=0.
    - Edge registers the final result with pass-through fields from the held ID/EX bundle, →IDLE.
    - Upstream advances on that same edge.
  - Op selects: MUL low 32 b, MULHU high 32 b, DIVU quotient, REMU remainder (unsigned).
  - Divide by zero: DIVU=0xFFFFFFFF, REMU=lhs, no exception.

## Timing
- Single-cycle op present in cycle N → ex_* valid in cycle N+1.
- MULDIV op present in cycle N:
  - ex_busy high cycles N..N+31 (32 cycles).
  - Result visible cycle N+33.
- Each stall cycle extends the above by one.
- ex_fwd_* is a combinational function of the output registers only; no input-to-output combinational path.
- ex_busy is combinational from FSM state, id_alu_op, id_en_ and id_exp_code.
- Flush in any BUSY cycle: next cycle IDLE, ex_busy=0, bubble.
- rst in any cycle has the same effect.

## Configuration
- YUTORINA_MULDIV_EN defined: iterative unit and FSM present as above.
- Not defined:
  - No FSM or datapath; ex_busy tied 0.
  - MUL/MULHU/DIVU/REMU complete in one cycle with ex_alu_out=0, ex_gpr_we_=DISABLE_, ex_exp_code=EXP_UNDEF_INSN.

## Test plan
- Reset, then ADD lhs=5 rhs=7 w_addr=3 we_ enabled → next cycle ex_alu_out=12, ex_fwd_addr=3, ex_fwd_out=12; all outputs at reset values during rst.
- ADD 0x7FFFFFFF+1 → ex_alu_out=0x80000000, ex_exp_code=EXP_OVERFLOW, ex_gpr_we_ disabled, ex_fwd_addr=GPR_ZERO.
- MUL 0xFFFFFFFF×2 (MULHU also) → ex_busy high exactly 32 cycles, bubbles meanwhile; MUL=0xFFFFFFFE, MULHU=0x00000001 at N+33.
- DIVU 100/7 → 14; REMU → 2; DIVU x/0 → 0xFFFFFFFF; REMU 9/0 → 9.
- DIVU with flush asserted at cnt=10 → next cycle IDLE, ex_busy=0, bubble, no result ever emitted; same with rst.
- Stall held 3 cycles mid-BUSY → result at N+36, ex_* unchanged during stall; with YUTORINA_MULDIV_EN undefined, MUL → EXP_UNDEF_INSN in 1 cycle, ex_busy never high.
